midi_transmitter: RTL
=====================

# midi_transmitter

Serial MIDI transmitter and counterpart of the team's MIDI receiver. Accepts a three-byte channel message (status, note, velocity) through a valid/ready handshake. Sends it on a single idle-high line as three 10-bit frames: start bit, 8 data bits MSB-first (matching the receiver's shift order), stop bit. Bit timing uses the same clock oversampling as the receiver, CLKS_PER_BIT clocks per bit (default 128 at a 4 MHz CLK gives 31250 baud).

## Interface
- CLKS_PER_BIT, 128, clocks per serial bit; legal range 2..1024; divider width is clog2(CLKS_PER_BIT).
- CLK  in  1  clock; all logic on the rising edge.
- RESET  in  1  reset, synchronous, active-low.
- START  in  1  request valid; a message is accepted when START && READY at a rising edge.
- STATUS  in  8  status byte; sampled on accept.
- NOTE  in  8  note byte; sampled on accept.
- VELOCITY  in  8  velocity byte; sampled on accept.
- READY  out  1  high when idle and able to accept.
- BUSY  out  1  high while a message is being shifted out; equals !READY.
- TX  out  1  serial line; idle high; registered.

## Operation
- Reset values: TX=1, READY=1, BUSY=0. The state register is IDLE and all counters are 0. START is ignored while RESET=0.
- FSM states: IDLE, START_BIT, DATA, STOP_BIT.
  - IDLE: on accept, latch the three bytes into msg[0..2]; byte_idx=0 (1 under running status skip, see Configuration); go to START_BIT.
  - START_BIT: TX=0 for CLKS_PER_BIT cycles; then load shift register from msg[byte_idx]; bit_idx=0; go to DATA.
  - DATA: TX=shift[7]; after each CLKS_PER_BIT cycles, shift left and increment bit_idx; after bit_idx=7 completes, go to STOP_BIT.
  - STOP_BIT: TX=1 for CLKS_PER_BIT cycles. Then, if byte_idx=2, go to IDLE; otherwise increment byte_idx and go to START_BIT.
- Divider: counts 0..CLKS_PER_BIT-1 and wraps; the bit-end tick fires at count CLKS_PER_BIT-1. The divider is held at 0 in IDLE.
- Input bytes are transmitted verbatim; no check is made that STATUS[7]=1.
- Inputs changing after accept have no effect on the frame in flight.
- START while BUSY is ignored and is not queued.
- Reset mid-message: at the next edge with RESET=0, the partial frame is abandoned, TX=1, and the block returns to IDLE with reset values.

## Timing
- Accept at edge k: READY/BUSY change and TX=0 from edge k+1. Latency from accept to start bit is 1 cycle.
- Frame bit i (0=start, 1..8 data, 9=stop) of byte b is driven over cycles k+1+(10b+i)·N through k+(10b+i+1)·N, where N=CLKS_PER_BIT.
- Stop bit is followed immediately by the next start bit; there is no inter-byte gap.
- READY=1 from edge k+1+30N. START held high accepts again at that edge, so the minimum inter-message idle is 1 cycle of TX=1.
- A full 3-byte message occupies 30N cycles (3840 at N=128).

## Configuration
- MIDI_TX_RUNNING_STATUS_EN defined:
  - A register last_status (reset 8'h00) holds the status byte of the last sent message.
  - On accept with STATUS[7]=1 and STATUS==last_status, byte 0 is skipped: only NOTE and VELOCITY are sent, READY returns at k+1+20N.
  - last_status is updated on every accept where STATUS[7]=1.
  - Reset clears last_status.
- Undefined: every message sends all 3 bytes; no last_status register exists.

## Structure
- Shared package midi_pkg:
  - state enum (IDLE, START_BIT, DATA, STOP_BIT);
  - constants MIDI_BITS_PER_FRAME=10, MIDI_BYTES_PER_MSG=3, MIDI_DEFAULT_CLKS_PER_BIT=128.
  - The receiver should import the same constants.
- One sub-module, midi_tx_baud: divider counter with clear and enable inputs and a one-cycle bit_tick output.

## Test plan
- Single message, N=128: STATUS=8'h90, NOTE=8'h3C, VELOCITY=8'h7F. Expect TX decoded per bit center as 0 10010000 1, 0 00111100 1, 0 01111111 1; READY high again exactly 3840 cycles after the start bit begins.
- START pulsed repeatedly while BUSY with different bytes: transmitted bytes unchanged, no second message follows.
- Back-to-back, START held high, N=2: two messages 90/3C/7F then 80/3C/00. Exactly 1 idle-high cycle between the stop bit and the next start bit; 60 cycles per message.
- RESET=0 during byte 1 bit 4: next edge TX=1, READY=1, BUSY=0. A new message afterwards transmits correctly from its start bit.
- MIDI_TX_RUNNING_STATUS_EN defined:
  - Two messages with STATUS=8'h90: second sends only NOTE and VELOCITY (20N cycles).
  - Third message with STATUS=8'h80 sends 3 bytes.
  - After reset, a repeat of 8'h90 sends 3 bytes.
- Loopback: TX wired to the receiver with N=128, message 90/45/40. Receiver LED shows 8'h45.

Source files
------------

// File: rtl/midi_pkg.sv
// Shared MIDI serial constants and the transmitter state encoding.
// Imported by both the MIDI transmitter and receiver.
package midi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START_BIT,
      DATA,
      STOP_BIT
   } state_t;

   localparam int MIDI_BITS_PER_FRAME       = 10;
   localparam int MIDI_BYTES_PER_MSG        = 3;
   localparam int MIDI_DEFAULT_CLKS_PER_BIT = 128;

endpackage

// File: rtl/midi_transmitter_if.sv
// Message handshake and serial line of the MIDI transmitter.
interface midi_transmitter_if;

   logic       START;
   logic [7:0] STATUS;
   logic [7:0] NOTE;
   logic [7:0] VELOCITY;
   logic       READY;
   logic       BUSY;
   logic       TX;

   modport master (
      output START, STATUS, NOTE, VELOCITY,
      input  READY, BUSY, TX
   );

   modport slave (
      input  START, STATUS, NOTE, VELOCITY,
      output READY, BUSY, TX
   );

endinterface

// File: rtl/midi_tx_baud.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled, pulses bit_tick on the last count.
module midi_tx_baud
   import midi_pkg::*;
#(
   parameter int CLKS_PER_BIT = MIDI_DEFAULT_CLKS_PER_BIT
) (
   input  logic CLK,
   input  logic RESET,
   input  logic clear,
   input  logic en,
   output logic bit_tick
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   assign bit_tick = en && (cnt == LAST);

   always_ff @(posedge CLK) begin
      if (!RESET || clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= bit_tick ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/midi_transmitter.sv
// Three-byte MIDI message serializer (start, 8 data bits MSB-first, stop per byte).
// Optional running-status byte skipping under `ifdef MIDI_TX_RUNNING_STATUS_EN.
module midi_transmitter
   import midi_pkg::*;
#(
   parameter int CLKS_PER_BIT = MIDI_DEFAULT_CLKS_PER_BIT
) (
   input  logic               CLK,
   input  logic               RESET,
   midi_transmitter_if.slave  bus
);

   state_t     state, state_d;
   logic [1:0] byte_idx, byte_idx_d;
   logic [2:0] bit_idx, bit_idx_d;
   logic [7:0] shift, shift_d;
   logic [7:0] msg [MIDI_BYTES_PER_MSG];
   logic       tx, tx_d;
   logic       idle, accept, skip, bit_tick;

   assign idle      = (state == IDLE);
   assign accept    = bus.START && idle && RESET;
   assign bus.READY = idle;
   assign bus.BUSY  = !idle;
   assign bus.TX    = tx;

   midi_tx_baud #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .CLK      (CLK),
      .RESET    (RESET),
      .clear    (idle),
      .en       (!idle),
      .bit_tick (bit_tick)
   );

`ifdef MIDI_TX_RUNNING_STATUS_EN
   logic [7:0] last_status;

   // A repeated status byte is implied by the receiver, so only note/velocity go out.
   assign skip = bus.STATUS[7] && (bus.STATUS == last_status);

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         last_status <= 8'h00;
      end else if (accept && bus.STATUS[7]) begin
         last_status <= bus.STATUS;
      end
   end
`else
   assign skip = 1'b0;
`endif

   always_comb begin
      state_d    = state;
      byte_idx_d = byte_idx;
      bit_idx_d  = bit_idx;
      shift_d    = shift;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_d    = START_BIT;
               byte_idx_d = skip ? 2'd1 : 2'd0;
            end
         end
         START_BIT: begin
            if (bit_tick) begin
               state_d   = DATA;
               shift_d   = msg[byte_idx];
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (bit_tick) begin
               shift_d   = {shift[6:0], 1'b0};
               bit_idx_d = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_d = STOP_BIT;
            end
         end
         STOP_BIT: begin
            if (bit_tick) begin
               if (byte_idx == 2'(MIDI_BYTES_PER_MSG - 1)) begin
                  state_d = IDLE;
               end else begin
                  byte_idx_d = byte_idx + 2'd1;
                  state_d    = START_BIT;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // TX is registered from the next state so the line changes on the same edge as the FSM.
      unique case (state_d)
         START_BIT: tx_d = 1'b0;
         DATA:      tx_d = shift_d[7];
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state    <= IDLE;
         byte_idx <= '0;
         bit_idx  <= '0;
         tx       <= 1'b1;
      end else begin
         state    <= state_d;
         byte_idx <= byte_idx_d;
         bit_idx  <= bit_idx_d;
         tx       <= tx_d;
      end
   end

   always_ff @(posedge CLK) begin
      shift <= shift_d;
      if (accept) begin
         msg[0] <= bus.STATUS;
         msg[1] <= bus.NOTE;
         msg[2] <= bus.VELOCITY;
      end
   end

endmodule
